// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU blocks (divider, multiplier).
// Holds field widths, canonical NaN encodings, operand classes and divider FSM states.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [FP_W-1:0] QNAN        = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] INVALID_NAN = 32'hFFC0_0000;

  // Divider quotient width (1 integer + 26 fraction bits) and accept-to-valid latency.
  localparam int QBITS   = 27;
  localparam int LATENCY = QBITS + 1;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  typedef enum logic [1:0] {IDLE, CALC, NORM} fpu_div_state_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic div_zero;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_classify.sv
// Classifies a binary32 magnitude as zero, normal, infinity or NaN.
// Subnormals are reported as zero (flush-to-zero); the sign bit does not affect the class.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [FP_W-2:0] op_mag_i,
  output fp_class_t       class_o
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;

  assign exp_field = op_mag_i[FP_W-2 -: EXP_W];
  assign man_field = op_mag_i[MAN_W-1:0];

  always_comb begin
    if (exp_field == '0) begin
      class_o = ZERO;
    end else if (exp_field == '1) begin
      class_o = (man_field == '0) ? INF : NAN;
    end else begin
      class_o = NORMAL;
    end
  end

endmodule

// File: rtl/fpu_div.sv
// Iterative binary32 divider: restoring radix-2 mantissa division, RNE rounding, flush-to-zero.
// One operation in flight; every operation, special or not, takes exactly LATENCY clocks.
module fpu_div
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            o_ready,
  input  logic [FP_W-1:0] i_op_a,
  input  logic [FP_W-1:0] i_op_b,
  output logic            valid_out,
  output logic [FP_W-1:0] o_res,
  output logic            o_overflow,
  output logic            o_underflow,
  output logic            o_invalid,
  output logic            o_div_zero
);

  fpu_div_state_t   state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [25:0]      rem_q, rem_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [23:0]      mb_q, mb_d;
  logic signed [9:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic             special_q, special_d;
  logic [FP_W-1:0]  spec_res_q, spec_res_d;
  fpu_flags_t       spec_flags_q, spec_flags_d;
  logic [FP_W-1:0]  res_q, res_d;
  fpu_flags_t       flags_q, flags_d;
  logic             valid_q, valid_d;

  fp_class_t cls_a, cls_b;

  fpu_classify u_cls_a (.op_mag_i(i_op_a[FP_W-2:0]), .class_o(cls_a));
  fpu_classify u_cls_b (.op_mag_i(i_op_b[FP_W-2:0]), .class_o(cls_b));

  // One restoring-division step on the registered remainder.
  logic [25:0] mb_ext, rem_sub;
  logic        rem_ge;

  assign mb_ext  = {2'b00, mb_q};
  assign rem_ge  = (rem_q >= mb_ext);
  assign rem_sub = rem_ge ? (rem_q - mb_ext) : rem_q;

  logic [MAN_W-1:0]  mant;
  logic              g_bit, r_bit, s_bit, round_up;
  logic [MAN_W:0]    mant_rnd;
  logic signed [9:0] e_norm, e_rnd;
  logic [FP_W-1:0]   pack_res;
  fpu_flags_t        pack_flags;

  always_comb begin
    if (q_q[QBITS-1]) begin
      mant   = q_q[25:3];
      g_bit  = q_q[2];
      r_bit  = q_q[1];
      s_bit  = q_q[0] | (|rem_q);
      e_norm = exp_q;
    end else begin
      mant   = q_q[24:2];
      g_bit  = q_q[1];
      r_bit  = q_q[0];
      s_bit  = |rem_q;
      e_norm = exp_q - 10'sd1;
    end
    round_up = g_bit & (r_bit | s_bit | mant[0]);
    // A carry into bit 23 means the significand rounded up to 2.0: fraction wraps to 0, exponent +1.
    mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    e_rnd    = e_norm + $signed({9'd0, mant_rnd[MAN_W]});

    pack_flags = '0;
    if (e_rnd >= 10'sd255) begin
      pack_res            = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pack_flags.overflow = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      pack_res             = {sign_q, {(FP_W-1){1'b0}}};
      pack_flags.underflow = 1'b1;
    end else begin
      pack_res = {sign_q, e_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    q_d          = q_q;
    mb_d         = mb_q;
    exp_d        = exp_q;
    sign_d       = sign_q;
    special_d    = special_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    res_d        = res_q;
    flags_d      = flags_q;
    valid_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d      = CALC;
          cnt_d        = '0;
          q_d          = '0;
          rem_d        = {3'b001, i_op_a[MAN_W-1:0]};
          mb_d         = {1'b1, i_op_b[MAN_W-1:0]};
          exp_d        = $signed({2'b00, i_op_a[30:23]}) - $signed({2'b00, i_op_b[30:23]})
                         + 10'(EXP_BIAS);
          sign_d       = i_op_a[FP_W-1] ^ i_op_b[FP_W-1];
          special_d    = 1'b1;
          spec_flags_d = '0;
          spec_res_d   = {sign_d, {(FP_W-1){1'b0}}};
          // Specials are resolved now but still ride through CALC for constant latency.
          if (cls_a == NAN || cls_b == NAN) begin
            spec_res_d           = QNAN;
            spec_flags_d.invalid = 1'b1;
          end else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
            spec_res_d           = INVALID_NAN;
            spec_flags_d.invalid = 1'b1;
          end else if (cls_a == INF) begin
            spec_res_d            = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags_d.overflow = 1'b1;
          end else if (cls_b == ZERO) begin
            spec_res_d            = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags_d.overflow = 1'b1;
            spec_flags_d.div_zero = 1'b1;
          end else if (cls_b == INF || cls_a == ZERO) begin
            spec_res_d = {sign_d, {(FP_W-1){1'b0}}};
          end else begin
            special_d = 1'b0;
          end
        end
      end

      CALC: begin
        q_d   = {q_q[QBITS-2:0], rem_ge};
        rem_d = rem_sub << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) begin
          state_d = NORM;
        end
      end

      NORM: begin
        res_d   = special_q ? spec_res_q : pack_res;
        flags_d = special_q ? spec_flags_q : pack_flags;
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      q_q          <= '0;
      mb_q         <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      special_q    <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      q_q          <= q_d;
      mb_q         <= mb_d;
      exp_q        <= exp_d;
      sign_q       <= sign_d;
      special_q    <= special_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      valid_q      <= valid_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign valid_out   = valid_q;
  assign o_res       = res_q;
  assign o_overflow  = flags_q.overflow;
  assign o_underflow = flags_q.underflow;
  assign o_invalid   = flags_q.invalid;
  assign o_div_zero  = flags_q.div_zero;

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div: scoreboard of expected results, independent handshake model,
// directed special/boundary cases, busy and reset behaviour, and random normal operands.
module tb_fpu_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        o_ready;
  logic [31:0] i_op_a = '0;
  logic [31:0] i_op_b = '0;
  logic        valid_out;
  logic [31:0] o_res;
  logic        o_overflow, o_underflow, o_invalid, o_div_zero;

  fpu_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .o_ready    (o_ready),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .valid_out  (valid_out),
    .o_res      (o_res),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow),
    .o_invalid  (o_invalid),
    .o_div_zero (o_div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;   // {overflow, underflow, invalid, div_zero}
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          busy_left = 0;
  int          last_acc = 0;
  bit          took = 1'b0;
  logic [31:0] cur_res = '0;
  logic [3:0]  cur_fl = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer quotient with remainder-based RNE, FTZ inputs and outputs.
  function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [63:0] ma, mb, num, q, r;
    bit          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    s = a[31] ^ b[31];
    if (a_nan || b_nan) return {4'b0010, 32'h7FC00000};
    if ((a_zero && b_zero) || (a_inf && b_inf)) return {4'b0010, 32'hFFC00000};
    if (a_inf) return {4'b1000, s, 8'hFF, 23'd0};
    if (b_zero) return {4'b1001, s, 8'hFF, 23'd0};
    if (b_inf || a_zero) return {4'b0000, s, 31'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    e  = ea - eb + 127;
    if (ma < mb) begin
      num = ma << 24;
      e   = e - 1;
    end else begin
      num = ma << 23;
    end
    q = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {4'b1000, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0100, s, 31'd0};
    return {4'b0000, s, e[7:0], q[22:0]};
  endfunction

  always @(posedge clk) cyc++;

  // Handshake model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy_left = 0;
    end else begin
      check("ready", {31'd0, o_ready}, {31'd0, busy_left == 0});
      if (valid_out) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res", o_res, e.res);
          check("flags", {28'd0, o_overflow, o_underflow, o_invalid, o_div_zero}, {28'd0, e.fl});
          check("latency", 32'(cyc - e.acc), 32'd28);
        end
      end
      if (busy_left > 0) begin
        busy_left--;
      end else if (valid_in) begin
        exp_t n;
        n.res = cur_res;
        n.fl  = cur_fl;
        n.acc = cyc + 1;
        sb.push_back(n);
        last_acc  = cyc + 1;
        busy_left = 28;
        took      = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [3:0] fl);
    i_op_a   = a;
    i_op_b   = b;
    cur_res  = res;
    cur_fl   = fl;
    took     = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      @(posedge clk);
      #1;
    end
    if (!took) check("accept_timeout", 32'd0, 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic send_ref(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] m;
    m = ref_div(a, b);
    send(a, b, m[31:0], m[35:32]);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    repeat (2) @(negedge clk);
    #1;
    check("rst_res", o_res, 32'd0);
    check("rst_ctl", {26'd0, valid_out, o_ready, o_overflow, o_underflow, o_invalid, o_div_zero},
          32'b010000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with hand-derived results.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);  // 6/2
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);  // 1/3, rounds up
    send(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b1001);  // 1/0
    send(32'h00000000, 32'h00000000, 32'hFFC00000, 4'b0010);  // 0/0
    send(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0010);  // NaN/1
    send(32'h7F800000, 32'h7F800000, 32'hFFC00000, 4'b0010);  // Inf/Inf
    send(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000);  // overflow
    send(32'h00800000, 32'h40000000, 32'h00000000, 4'b0100);  // underflow to zero
    send(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000);  // smallest normal survives
    send(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000);  // largest finite survives
    send(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b1000);  // Inf / -2
    send(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000);  // 1/Inf
    send(32'h80000000, 32'h40400000, 32'h80000000, 4'b0000);  // -0/3
    send(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000);  // -6/2
    send(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000);  // subnormal dividend flushed
    drain();

    // Busy: operands held valid during CALC are ignored; next accept lands 29 clocks later.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    a1 = last_acc;
    send(32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000);  // 10/5
    a2 = last_acc;
    check("accept_spacing", 32'(a2 - a1), 32'd29);
    drain();

    // Reset mid-operation: outputs clear, no result emerges afterwards.
    send(32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000);
    a1 = last_acc;
    for (int i = 0; i < 40 && cyc < a1 + 10; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_res", o_res, 32'd0);
    check("midrst_ctl", {26'd0, valid_out, o_ready, o_overflow, o_underflow, o_invalid, o_div_zero},
          32'b010000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_res", o_res, 32'd0);

    // Random normal operands against the reference model, back to back.
    for (int i = 0; i < 1500; i++) begin
      send_ref(rand_normal(), rand_normal());
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
